// File: rtl/addsub_pipe.sv
// Multi-lane add/sub/accumulate pipeline, STAGES deep, ready/valid on both sides.
// Define ADDSUB_PIPE_SAT_EN for saturating arithmetic; default build wraps modulo 2^W.
module addsub_pipe #(
    parameter int unsigned W      = 12,
    parameter int unsigned LANES  = 2,
    parameter int unsigned STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [LANES*W-1:0]   a,
    input  logic [LANES*W-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   y,
    output logic [LANES-1:0]     ovf
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    op_e                 op_sel;
    logic                stall;
    logic                accept;

    logic [STAGES-1:0]   valid_q;
    logic [LANES*W-1:0]  y_q   [STAGES];
    logic [LANES-1:0]    ovf_q [STAGES];

    logic [LANES*W-1:0]  acc_q;
    logic [LANES*W-1:0]  acc_d;
    logic [LANES*W-1:0]  res_d;
    logic [LANES-1:0]    rovf_d;

    logic [W:0]          sum_w;
    logic [W:0]          diff_w;
    logic [W:0]          accs_w;
    logic [W-1:0]        add_r;
    logic [W-1:0]        sub_r;
    logic [W-1:0]        acc_r;

    assign op_sel    = op_e'(op);
    assign out_valid = valid_q[STAGES-1];
    assign y         = y_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;

    always_comb begin
        res_d  = '0;
        rovf_d = '0;
        acc_d  = acc_q;
        sum_w  = '0;
        diff_w = '0;
        accs_w = '0;
        add_r  = '0;
        sub_r  = '0;
        acc_r  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            sum_w  = {1'b0, a[l*W +: W]} + {1'b0, b[l*W +: W]};
            diff_w = {1'b0, a[l*W +: W]} - {1'b0, b[l*W +: W]};
            accs_w = {1'b0, acc_q[l*W +: W]} + {1'b0, a[l*W +: W]};
`ifdef ADDSUB_PIPE_SAT_EN
            add_r = sum_w[W]  ? '1 : sum_w[W-1:0];
            sub_r = diff_w[W] ? '0 : diff_w[W-1:0];
            acc_r = accs_w[W] ? '1 : accs_w[W-1:0];
`else
            add_r = sum_w[W-1:0];
            sub_r = diff_w[W-1:0];
            acc_r = accs_w[W-1:0];
`endif
            case (op_sel)
                OP_ADD: begin
                    res_d[l*W +: W] = add_r;
                    rovf_d[l]       = sum_w[W];
                end
                OP_SUB: begin
                    res_d[l*W +: W] = sub_r;
                    rovf_d[l]       = diff_w[W];
                end
                OP_ACC: begin
                    res_d[l*W +: W] = acc_r;
                    rovf_d[l]       = accs_w[W];
                    if (accept) acc_d[l*W +: W] = acc_r;
                end
                OP_CLR: begin
                    if (accept) acc_d[l*W +: W] = '0;
                end
                default: ;
            endcase
        end
    end

    // Accumulators commit at acceptance so chained ACCs see the fresh value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            acc_q   <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                y_q[k]   <= '0;
                ovf_q[k] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            if (!stall) begin
                valid_q[0] <= accept;
                y_q[0]     <= res_d;
                ovf_q[0]   <= rovf_d;
                for (int unsigned k = 1; k < STAGES; k++) begin
                    valid_q[k] <= valid_q[k-1];
                    y_q[k]     <= y_q[k-1];
                    ovf_q[k]   <= ovf_q[k-1];
                end
            end
        end
    end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Multi-lane, parametrised-latency add/subtract/accumulate pipeline with ready/valid handshakes on both sides. It is the generalisation of the team's single-lane `start`/`valid` registered adder: configurable lane count, pipeline depth and operation, per-lane overflow flags, and output backpressure. It sits between an operand producer and a result consumer in the datapath, and each accepted transaction yields exactly one result.

## Interface
- `W`, default 12: lane data width in bits, minimum 2.
- `LANES`, default 2: number of independent lanes, minimum 1.
- `STAGES`, default 2: pipeline latency in cycles, minimum 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand transaction offered.
- `in_ready`  out  1  block can accept a transaction this cycle.
- `op`  in  2  operation select: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- `a`  in  LANES*W  operand A; lane i occupies bits [i*W +: W].
- `b`  in  LANES*W  operand B; same packing as `a`.
- `out_valid`  out  1  result presented.
- `out_ready`  in  1  consumer takes the result this cycle.
- `y`  out  LANES*W  per-lane result; same packing as `a`.
- `ovf`  out  LANES  per-lane overflow/borrow flag, aligned with `y`.

## Operation
- A transaction is accepted on a rising edge where `in_valid && in_ready`.
- A result is consumed on a rising edge where `out_valid && out_ready`.
- All lanes share one handshake and one `op`. Each lane computes independently; arithmetic is unsigned.
- **ADD:** `y = a + b` mod 2^W. `ovf` = carry out of bit W-1.
- **SUB:** `y = a - b` mod 2^W. `ovf` = borrow, i.e. a < b.
- **ACC:** per-lane accumulator `acc <= acc + a`; `b` is ignored. `y` = the new `acc`; `ovf` = carry out of that addition.
- **CLR:** `acc <= 0`, `y = 0`, `ovf = 0`.
- The accumulator updates at the acceptance edge, so back-to-back ACC transactions chain without hazard. `acc` is never updated by a stalled or unaccepted cycle.
- Pipeline state: `STAGES` registers of {valid, y, ovf}. Stage 0 is loaded on acceptance; the last stage drives the outputs.
- Global stall: `stall = out_valid && !out_ready`.
  - While `stall` is high, every stage holds and `in_ready = 0`.
  - Otherwise all stages shift by one and `in_ready = 1`.
  - `in_ready` depends combinationally on `out_ready`.
  - Bubbles do not compress during a stall.
- Results leave in acceptance order. None are dropped or duplicated.
- No state machine beyond the valid pipeline.

## Timing
- Reset (async assert, synchronous-to-`clk` deassert by the system):
  - all stage valids, `out_valid`, `y`, `ovf` and all accumulators go to 0 immediately;
  - `in_ready` = 1 while reset is not asserted.
- Latency: a transaction accepted at edge N, with no stall, produces `out_valid = 1` and valid `y`/`ovf` after edge N+STAGES-1. For STAGES=1 this is the cycle after acceptance.
- Throughput: one transaction per cycle while `out_ready = 1`.
- While `out_valid && !out_ready`, `y` and `ovf` are held stable.
- Simultaneous accept and consume in the same cycle is legal and sustains full rate.
- Reset mid-operation:
  - in-flight transactions are discarded and accumulators cleared;
  - no result for them is ever presented.
- `op` and operands are sampled only at acceptance; their values in other cycles are don't-care.

## Configuration
- Macro: `ADDSUB_PIPE_SAT_EN`.
- **Defined:** saturating arithmetic.
  - ADD and ACC clamp to 2^W-1 on carry.
  - SUB clamps to 0 on borrow.
  - The accumulator stores the clamped value.
  - `ovf` still flags that clamping occurred.
- **Undefined:** wrap-around modulo 2^W as specified under Operation.

## Test plan
(Configuration for all scenarios: W=12, LANES=2, STAGES=2.)
- **Reset:** hold `rst_n = 0` for 3 cycles with `in_valid = 1` -> `out_valid = 0`, `y = 0`, `ovf = 0` throughout. No result appears after release until a new accept.
- **ADD:** lane0 a=0x3FF b=0x001, lane1 a=0x001 b=0xFFF, accepted at edge N -> after edge N+1: `out_valid = 1`, y0=0x400, y1=0x000, `ovf = 2'b10`. With `ADDSUB_PIPE_SAT_EN`, y1=0xFFF.
- **SUB:** lane0 a=0x005 b=0x007, lane1 a=0x010 b=0x003 -> y0=0xFFE, y1=0x00D, `ovf = 2'b01`. With `ADDSUB_PIPE_SAT_EN`, y0=0x000.
- **Accumulate:** CLR, then three ACC with a=0x100 on both lanes, back-to-back -> results 0x000, 0x100, 0x200, 0x300 on consecutive cycles. A fourth ACC with a=0xE00 -> y=0x100, `ovf = 2'b11` (SAT build: 0xFFF).
- **Backpressure:** issue 4 back-to-back ADDs with `out_ready = 0` ->
  - `in_ready` falls in the first cycle `out_valid` is high;
  - `y` stays stable while stalled;
  - after raising `out_ready`, the 4 results emerge in order on 4 consecutive cycles, none lost or duplicated.
- **Reset mid-flight:** accept 2 transactions, then pulse `rst_n` low between edges -> `out_valid` drops immediately and accumulators read 0. After release, a subsequent ACC a=0x001 yields 0x001.
